radix_digit_converter: RTL and testbench

//   Sequential converter from a 16-bit binary value to 8 packed 4-bit digits.

---
 rtl/radix_digit_converter.sv | 146 ++++++++++++++
 tb/tb_radix_digit_converter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/radix_digit_converter.sv
// Converts a binary value into N_DIGITS packed digits (octal/decimal/hex) by
// repeated restoring division, one quotient bit per clock.
module radix_digit_converter #(
  parameter int WIDTH    = 16,
  parameter int N_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      number,
  input  logic [1:0]            radix,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   blank
);

  localparam int CW = $clog2(WIDTH);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [N_DIGITS-1:0] BLANK_RST = {{(N_DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, DIV, STORE, DONE} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      dividend_q, dividend_d;
  logic [WIDTH-1:0]      quot_q, quot_d;
  logic [4:0]            rem_q, rem_d;
  logic [4:0]            base_q, base_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] work_q, work_d;
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [N_DIGITS-1:0]   blank_q, blank_d;

  logic [5:0]            rem_shift;
  logic                  rem_ge;
  logic [4*N_DIGITS-1:0] work_new;

  // A position is dark when it and every more significant digit are zero;
  // position 0 always lights so that zero shows a single "0".
  function automatic logic [N_DIGITS-1:0] blank_mask(input logic [4*N_DIGITS-1:0] w);
    logic zero_run;
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (w[i*4 +: 4] == 4'd0);
      blank_mask[i] = (i > 0) && zero_run;
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    work_d     = work_q;
    digits_d   = digits_q;
    blank_d    = blank_q;

    rem_shift = {rem_q, dividend_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, base_q};
    work_new  = work_q;
    work_new[idx_q*4 +: 4] = rem_q[3:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          dividend_d = number;
          quot_d     = '0;
          rem_d      = '0;
          cnt_d      = '0;
          idx_d      = '0;
          case (radix)
            2'd0:    base_d = 5'd8;
            2'd1:    base_d = 5'd10;
            default: base_d = 5'd16;
          endcase
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d      = rem_ge ? 5'(rem_shift - {1'b0, base_q}) : rem_shift[4:0];
        quot_d     = {quot_q[WIDTH-2:0], rem_ge};
        dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = STORE;
      end
      STORE: begin
        work_d     = work_new;
        dividend_d = quot_q;
        quot_d     = '0;
        rem_d      = '0;
        cnt_d      = '0;
        // Outputs load together with the last digit so they become visible
        // in the DONE cycle, alongside the done pulse.
        if (idx_q == IW'(N_DIGITS - 1)) begin
          digits_d = work_new;
          blank_d  = blank_mask(work_new);
          state_d  = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = DIV;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      work_q     <= '0;
      digits_q   <= '0;
      blank_q    <= BLANK_RST;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      work_q     <= work_d;
      digits_q   <= digits_d;
      blank_q    <= blank_d;
    end
  end

  assign busy   = (state_q == DIV) || (state_q == STORE);
  assign done   = (state_q == DONE);
  assign digits = digits_q;
  assign blank  = blank_q;

endmodule

// File: tb/tb_radix_digit_converter.sv
// Self-checking bench for radix_digit_converter: directed vectors plus
// randomized conversions checked against an arithmetic digit model.
module tb_radix_digit_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] number = '0;
  logic [1:0]  radix = '0;
  logic        busy;
  logic        done;
  logic [31:0] digits;
  logic [7:0]  blank;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  radix_digit_converter #(.WIDTH(16), .N_DIGITS(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .number (number),
    .radix  (radix),
    .busy   (busy),
    .done   (done),
    .digits (digits),
    .blank  (blank)
  );

  // Reference: plain modulo/divide digit extraction and leading-zero search.
  function automatic void model(input logic [15:0] n, input logic [1:0] r,
                                output logic [31:0] d, output logic [7:0] b);
    int base, v, top;
    base = (r == 2'd0) ? 8 : (r == 2'd1) ? 10 : 16;
    v = int'(n);
    top = 0;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      d[i*4 +: 4] = 4'(v % base);
      if (v % base != 0) top = i;
      v = v / base;
    end
    for (int i = 0; i < 8; i++) b[i] = (i > top);
  endfunction

  // Presents start for one edge from IDLE; returns in cycle 1 of the conversion
  // with the inputs scrambled to show they are not re-sampled.
  task automatic issue_start(input logic [15:0] n, input logic [1:0] r);
    @(posedge clk); #1;
    start = 1'b1; number = n; radix = r;
    @(posedge clk); #1;
    start = 1'b0;
    number = 16'($urandom);
    radix = 2'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (digits !== 32'h0) $display("[TB] FAIL reset_digits: got %h expected 00000000", digits); else passed++;
    total++; if (blank !== 8'hFE) $display("[TB] FAIL reset_blank: got %b expected 11111110", blank); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk); #1;
        if (done !== 1'b0 || digits !== 32'h0 || blank !== 8'hFE) seen++;
      end
      total++; if (seen != 0) $display("[TB] FAIL idle_hold: got %0d disturbed cycles expected 0", seen); else passed++;
    end
  endtask

  task automatic test_known();
    logic [15:0] nums [8] = '{16'd1234, 16'hBEEF, 16'hBEEF, 16'd65535, 16'd65535, 16'd0, 16'd0, 16'd0};
    logic [1:0]  rads [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1, 2'd3};
    logic [31:0] expd [8] = '{32'h0000_1234, 32'h0000_BEEF, 32'h0000_BEEF, 32'h0017_7777,
                              32'h0006_5535, 32'h0, 32'h0, 32'h0};
    logic [7:0]  expb [8] = '{8'hF0, 8'hF0, 8'hF0, 8'hC0, 8'hE0, 8'hFE, 8'hFE, 8'hFE};
    int lat;
    for (int k = 0; k < 8; k++) begin
      issue_start(nums[k], rads[k]);
      total++; if (busy !== 1'b1) $display("[TB] FAIL known%0d_busy: got %b expected 1", k, busy); else passed++;
      wait_done(lat);
      total++; if (lat != 137) $display("[TB] FAIL known%0d_latency: got %0d expected 137", k, lat); else passed++;
      total++; if (busy !== 1'b0) $display("[TB] FAIL known%0d_busy_done: got %b expected 0", k, busy); else passed++;
      total++; if (digits !== expd[k]) $display("[TB] FAIL known%0d_digits: got %h expected %h", k, digits, expd[k]); else passed++;
      total++; if (blank !== expb[k]) $display("[TB] FAIL known%0d_blank: got %b expected %b", k, blank, expb[k]); else passed++;
    end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) $display("[TB] FAIL done_pulse_width: got %b expected 0", done); else passed++;
  endtask

  task automatic test_random();
    logic [15:0] n;
    logic [1:0]  r;
    logic [31:0] ed;
    logic [7:0]  eb;
    int lat;
    for (int k = 0; k < 12; k++) begin
      n = 16'($urandom);
      if (k < 3) n = n >> (4 * k + 4);
      r = 2'($urandom);
      model(n, r, ed, eb);
      issue_start(n, r);
      wait_done(lat);
      total++; if (lat != 137) $display("[TB] FAIL rand%0d_latency: got %0d expected 137", k, lat); else passed++;
      total++; if (digits !== ed) $display("[TB] FAIL rand%0d_digits n=%0d r=%0d: got %h expected %h", k, n, r, digits, ed); else passed++;
      total++; if (blank !== eb) $display("[TB] FAIL rand%0d_blank n=%0d r=%0d: got %b expected %b", k, n, r, blank, eb); else passed++;
    end
  endtask

  task automatic test_ignore_start();
    int lat, bad;
    issue_start(16'hBEEF, 2'd2);
    wait_done(lat);
    issue_start(16'd1234, 2'd1);
    lat = 1;
    bad = 0;
    while (done !== 1'b1 && lat < 400) begin
      if (digits !== 32'h0000_BEEF || blank !== 8'hF0 || busy !== 1'b1) bad++;
      if (lat == 50) begin
        start = 1'b1; number = 16'd99; radix = 2'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    total++; if (bad != 0) $display("[TB] FAIL hold_stable: got %0d unstable cycles expected 0", bad); else passed++;
    total++; if (lat != 137) $display("[TB] FAIL ignore_latency: got %0d expected 137", lat); else passed++;
    total++; if (digits !== 32'h0000_1234) $display("[TB] FAIL ignore_digits: got %h expected 00001234", digits); else passed++;
    total++; if (blank !== 8'hF0) $display("[TB] FAIL ignore_blank: got %b expected 11110000", blank); else passed++;
    begin
      int extra = 0;
      for (int i = 0; i < 160; i++) begin
        @(posedge clk); #1;
        if (done === 1'b1 || busy === 1'b1) extra++;
      end
      total++; if (extra != 0) $display("[TB] FAIL no_queued_start: got %0d active cycles expected 0", extra); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ed;
    logic [7:0]  eb;
    int lat, seen;
    issue_start(16'hABCD, 2'd2);
    for (lat = 1; lat < 70; lat++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", busy); else passed++;
    total++; if (digits !== 32'h0) $display("[TB] FAIL midrst_digits: got %h expected 00000000", digits); else passed++;
    total++; if (blank !== 8'hFE) $display("[TB] FAIL midrst_blank: got %b expected 11111110", blank); else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    total++; if (seen != 0) $display("[TB] FAIL midrst_no_done: got %0d done cycles expected 0", seen); else passed++;
    model(16'd4321, 2'd1, ed, eb);
    issue_start(16'd4321, 2'd1);
    wait_done(lat);
    total++; if (lat != 137) $display("[TB] FAIL postrst_latency: got %0d expected 137", lat); else passed++;
    total++; if (digits !== ed) $display("[TB] FAIL postrst_digits: got %h expected %h", digits, ed); else passed++;
    total++; if (blank !== eb) $display("[TB] FAIL postrst_blank: got %b expected %b", blank, eb); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea, eb2;
    logic [7:0]  ba, bb;
    int lat, t;
    model(16'd777, 2'd0, ea, ba);
    model(16'd40961, 2'd1, eb2, bb);
    @(posedge clk); #1;
    start = 1'b1; number = 16'd777; radix = 2'd0;
    @(posedge clk); #1;
    number = 16'd40961; radix = 2'd1;
    wait_done(lat);
    total++; if (lat != 137) $display("[TB] FAIL b2b_first_latency: got %0d expected 137", lat); else passed++;
    total++; if (digits !== ea) $display("[TB] FAIL b2b_first_digits: got %h expected %h", digits, ea); else passed++;
    total++; if (blank !== ba) $display("[TB] FAIL b2b_first_blank: got %b expected %b", blank, ba); else passed++;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (done !== 1'b1 && t < 400);
    start = 1'b0;
    total++; if (t != 138) $display("[TB] FAIL b2b_period: got %0d expected 138", t); else passed++;
    total++; if (digits !== eb2) $display("[TB] FAIL b2b_second_digits: got %h expected %h", digits, eb2); else passed++;
    total++; if (blank !== bb) $display("[TB] FAIL b2b_second_blank: got %b expected %b", blank, bb); else passed++;
  endtask

  initial begin
    test_reset();
    test_known();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
